// File: rtl/next_if_pkg.sv
// Shared types and defaults for the next_initiator block.
//   state_e      : sequencing FSM states (IDLE/START/ISSUE/DRAIN)
//   res_entry_t  : one result-buffer entry {last, data}
//   *_DEF        : default widths/depth used by the modules' parameters
package next_if_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int CNT_W_DEF     = 8;
  localparam int RES_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Data field is DATA_W_DEF wide; the block is built at the default width.
  typedef struct packed {
    logic                  last;
    logic [DATA_W_DEF-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/next_initiator_if.sv
// Bundle of all handshake/bus signals of next_initiator.
//   host command : cmd_valid/cmd_ready, cmd_count, cmd_k_base, cmd_k_step
//   responder    : EN_start/RDY_start, EN_next/RDY_next, next_k, next
//   result       : res_valid/res_ready, res_data, res_last
//   status       : busy, done
// modport master = the initiator, modport slave = host + responder + sink.
interface next_initiator_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_count;
  logic [DATA_W-1:0] cmd_k_base;
  logic [DATA_W-1:0] cmd_k_step;

  logic              EN_start;
  logic              RDY_start;
  logic              EN_next;
  logic              RDY_next;
  logic [DATA_W-1:0] next_k;
  logic [DATA_W-1:0] next;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_count, cmd_k_base, cmd_k_step,
    output cmd_ready,
    output EN_start, input RDY_start,
    output EN_next,  input RDY_next,
    output next_k,   input next,
    output res_valid, res_data, res_last,
    input  res_ready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_count, cmd_k_base, cmd_k_step,
    input  cmd_ready,
    input  EN_start, output RDY_start,
    input  EN_next,  output RDY_next,
    input  next_k,   output next,
    input  res_valid, res_data, res_last,
    output res_ready,
    input  busy, done
  );
endinterface

// File: rtl/next_res_fifo.sv
// Result buffer: 2-entry first-word-fall-through FIFO.
//   CLK, RST   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, valid whenever !empty
//   full/empty : occupancy flags
module next_res_fifo
  import next_if_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  res_entry_t push_data,
  input  logic       pop,
  output res_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int CNT_BITS = $clog2(DEPTH + 1);

  // Single-bit pointers: storage is exactly two entries.
  res_entry_t          mem_q [2];
  res_entry_t          mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_BITS'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
      2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/next_initiator.sv
// Initiator that issues one start call followed by cmd_count next calls to a
// responder, with k = base, base+step, base+2*step, ... and streams the
// returned values out through a 2-entry result buffer.
//   CLK  : sole clock, rising edge
//   RST  : synchronous active-high reset; aborts any operation in progress
//   bus  : next_initiator_if.master (command, responder, result, status)
module next_initiator
  import next_if_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input logic               CLK,
  input logic               RST,
  next_initiator_if.master  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] step_q, step_d;

  logic       cmd_ready_c, en_start_c, en_next_c, done_c;
  logic       fifo_full, fifo_empty, push, pop;
  res_entry_t push_entry, head;

  next_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    k_d         = k_q;
    step_d      = step_q;
    cmd_ready_c = 1'b0;
    en_start_c  = 1'b0;
    en_next_c   = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          rem_d   = bus.cmd_count;
          k_d     = bus.cmd_k_base;
          step_d  = bus.cmd_k_step;
          state_d = ST_START;
        end
      end
      ST_START: begin
        en_start_c = bus.RDY_start;
        if (bus.RDY_start) state_d = (rem_q == '0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        // Only call when the returned value has somewhere to land.
        if (bus.RDY_next && (rem_q != '0) && !fifo_full) begin
          en_next_c = 1'b1;
          k_d       = k_q + step_q;  // running k, wraps silently
          rem_d     = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      k_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      step_q  <= step_d;
    end
  end

  // Responder returns next in the same cycle as the call.
  assign push            = en_next_c & ~RST;
  assign push_entry.last = (rem_q == CNT_W'(1));
  assign push_entry.data = bus.next;
  assign pop             = bus.res_valid & bus.res_ready;

  // Outputs are masked while RST is high so nothing fires in the reset cycle,
  // even though the registered state only clears on the following edge.
  assign bus.cmd_ready = cmd_ready_c & ~RST;
  assign bus.EN_start  = en_start_c & ~RST;
  assign bus.EN_next   = en_next_c & ~RST;
  assign bus.next_k    = RST ? '0 : k_q;
  assign bus.res_valid = ~fifo_empty & ~RST;
  assign bus.res_data  = RST ? '0 : head.data;
  assign bus.res_last  = head.last & ~fifo_empty & ~RST;
  assign bus.busy      = (state_q != ST_IDLE) & ~RST;
  assign bus.done      = done_c & ~RST;

endmodule

// File: tb/tb_next_initiator.sv
module tb_next_initiator;

  typedef struct packed { logic last; logic [31:0] data; } res_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  next_initiator_if #(.DATA_W(32), .CNT_W(8)) bus();
  next_initiator #(.DATA_W(32), .CNT_W(8), .RES_DEPTH(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Responder: zero-latency, next = k + 1.
  assign bus.next = bus.next_k + 32'd1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Ready drivers: mode 0 = low, 1 = high, 2 = random each cycle.
  int rs_mode = 1, rn_mode = 1, rr_mode = 1;
  function automatic logic pick(input int m);
    if (m == 2) return 1'($urandom_range(0, 1));
    return (m == 1);
  endfunction
  always @(posedge CLK) begin
    #1;
    bus.RDY_start = pick(rs_mode);
    bus.RDY_next  = pick(rn_mode);
    bus.res_ready = pick(rr_mode);
  end

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Scoreboard state
  logic [31:0] exp_k[$];
  res_t        exp_res[$];
  logic [31:0] seen_k[$];
  int          en_cyc[$];
  bit          active = 0, start_pend = 0, done_pend = 0;
  int          op_count = 0, start_cyc = 0, last_pop = 0;
  int          last_done_cyc = -1, last_acc_cyc = -1;
  int          n_en_start = 0, n_en_next = 0, n_pop = 0, n_done = 0, n_acc = 0, n_abort = 0;
  logic [31:0] mk, mb, ms;
  res_t        mr;

  // Monitor: compares DUT activity against expectations queued at command
  // acceptance (k_i = base + i*step, result = k_i + 1, last on final call).
  always @(negedge CLK) begin
    if (RST) begin
      chk(bus.EN_start == 0, "rst_en_start", bus.EN_start, 0);
      chk(bus.EN_next == 0, "rst_en_next", bus.EN_next, 0);
      chk(bus.res_valid == 0, "rst_res_valid", bus.res_valid, 0);
      chk(bus.res_last == 0, "rst_res_last", bus.res_last, 0);
      chk(bus.done == 0, "rst_done", bus.done, 0);
      chk(bus.busy == 0, "rst_busy", bus.busy, 0);
      chk(bus.next_k == 0, "rst_next_k", bus.next_k, 0);
      chk(bus.res_data == 0, "rst_res_data", bus.res_data, 0);
      if (active) n_abort++;
      exp_k.delete();
      exp_res.delete();
      active = 0; start_pend = 0; done_pend = 0;
    end else begin
      chk(bus.busy == active, "busy", bus.busy, active);
      chk(bus.cmd_ready == !active, "cmd_ready", bus.cmd_ready, !active);
      if (!active) chk(bus.res_valid == 0, "res_valid_idle", bus.res_valid, 0);
      if (bus.EN_start) begin
        n_en_start++;
        chk(bus.RDY_start == 1, "en_start_without_rdy", bus.RDY_start, 1);
        chk(start_pend, "en_start_once", 0, 1);
        start_pend = 0;
        start_cyc = cyc;
      end
      if (bus.EN_next) begin
        n_en_next++;
        en_cyc.push_back(cyc);
        seen_k.push_back(bus.next_k);
        chk(bus.RDY_next == 1, "en_next_without_rdy", bus.RDY_next, 1);
        if (exp_k.size() == 0) chk(0, "en_next_extra", bus.next_k, 0);
        else begin
          mk = exp_k.pop_front();
          chk(bus.next_k == mk, "next_k", bus.next_k, mk);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        n_pop++;
        last_pop = cyc;
        if (exp_res.size() == 0) chk(0, "res_extra", bus.res_data, 0);
        else begin
          mr = exp_res.pop_front();
          chk({bus.res_last, bus.res_data} == mr, "res", {bus.res_last, bus.res_data}, mr);
        end
      end
      if (bus.done) begin
        n_done++;
        last_done_cyc = cyc;
        chk(done_pend, "done_unexpected", 1, 0);
        if (op_count == 0) chk(cyc == start_cyc + 1, "done_timing_cnt0", cyc, start_cyc + 1);
        else chk(cyc == last_pop + 1, "done_timing", cyc, last_pop + 1);
        chk(exp_res.size() == 0 && exp_k.size() == 0, "done_not_drained", exp_res.size(), 0);
        done_pend = 0;
        active = 0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_acc++;
        last_acc_cyc = cyc;
        op_count = int'(bus.cmd_count);
        mb = bus.cmd_k_base;
        ms = bus.cmd_k_step;
        for (int i = 0; i < op_count; i++) begin
          mk = mb + 32'(i) * ms;
          exp_k.push_back(mk);
          mr.last = (i == op_count - 1);
          mr.data = mk + 32'd1;
          exp_res.push_back(mr);
        end
        active = 1; start_pend = 1; done_pend = 1;
      end
    end
  end

  task automatic run_cmd(input int cnt, input logic [31:0] b, input logic [31:0] s);
    int t = 0;
    int a0 = n_acc;
    @(posedge CLK); #1;
    bus.cmd_count = 8'(cnt); bus.cmd_k_base = b; bus.cmd_k_step = s; bus.cmd_valid = 1;
    do begin @(posedge CLK); t++; end while (n_acc == a0 && t < 200);
    #1 bus.cmd_valid = 0;
    if (n_acc == a0) chk(0, "cmd_accept_timeout", t, 200);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 1000) begin @(posedge CLK); t++; end
    chk(n_done > d0, "done_timeout", n_done, d0 + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0, p0, d0, a0, t;
    bus.cmd_valid = 0; bus.cmd_count = 0; bus.cmd_k_base = 0; bus.cmd_k_step = 0;
    RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk(bus.cmd_ready == 1, "cmd_ready_after_rst", bus.cmd_ready, 1);

    // Basic sequencing: 10,15,20 -> 11,16,21
    s0 = n_en_start; d0 = n_done; en_cyc.delete(); seen_k.delete();
    run_cmd(3, 32'd10, 32'd5);
    wait_done(d0);
    chk(n_en_start - s0 == 1, "t1_starts", n_en_start - s0, 1);
    chk(en_cyc.size() == 3, "t1_calls", en_cyc.size(), 3);
    if (en_cyc.size() == 3) chk(en_cyc[2] - en_cyc[0] == 2, "t1_back_to_back", en_cyc[2] - en_cyc[0], 2);

    // Backpressure: only two calls fit with the sink stalled
    rr_mode = 0; n0 = n_en_next; d0 = n_done;
    run_cmd(4, $urandom, $urandom);
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk(n_en_next - n0 == 2, "t2_two_calls", n_en_next - n0, 2);
    chk(bus.res_valid && bus.busy, "t2_stalled_full", {bus.res_valid, bus.busy}, 2'b11);
    p0 = n_pop; rr_mode = 1;
    wait_done(d0);
    chk(n_pop - p0 == 4, "t2_pops", n_pop - p0, 4);

    // Responder not ready
    rs_mode = 0; rn_mode = 0; s0 = n_en_start; d0 = n_done;
    run_cmd(6, $urandom, $urandom);
    repeat (5) @(posedge CLK);
    chk(n_en_start == s0, "t3_no_start_while_not_ready", n_en_start - s0, 0);
    rs_mode = 1; rn_mode = 2; rr_mode = 2;
    wait_done(d0);
    rn_mode = 1; rr_mode = 1;

    // count == 0
    s0 = n_en_start; n0 = n_en_next; p0 = n_pop; d0 = n_done;
    run_cmd(0, 32'd7, 32'd3);
    wait_done(d0);
    chk(n_en_start - s0 == 1, "t4_start", n_en_start - s0, 1);
    chk(n_en_next == n0, "t4_no_next", n_en_next - n0, 0);
    chk(n_pop == p0, "t4_no_result", n_pop - p0, 0);

    // wrap
    seen_k.delete(); d0 = n_done;
    run_cmd(2, 32'hFFFF_FFFF, 32'd1);
    wait_done(d0);
    chk(seen_k.size() == 2, "t5_calls", seen_k.size(), 2);
    if (seen_k.size() == 2) begin
      chk(seen_k[0] == 32'hFFFF_FFFF, "t5_k0", seen_k[0], 32'hFFFF_FFFF);
      chk(seen_k[1] == 32'h0, "t5_k1", seen_k[1], 0);
    end

    // Reset one cycle after the second call of a count=5 command
    n0 = n_en_next; t = 0;
    run_cmd(5, $urandom, $urandom);
    while (n_en_next - n0 < 2 && t < 100) begin @(posedge CLK); t++; end
    chk(n_en_next - n0 == 2, "t6_second_call", n_en_next - n0, 2);
    #1 RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk(bus.res_valid == 0, "t6_fifo_empty", bus.res_valid, 0);
    chk(bus.cmd_ready == 1, "t6_idle", bus.cmd_ready, 1);
    d0 = n_done;
    run_cmd(3, $urandom, $urandom);
    wait_done(d0);

    // cmd_valid held through an operation
    a0 = n_acc; t = 0;
    @(posedge CLK); #1;
    bus.cmd_count = 8'd3; bus.cmd_k_base = $urandom; bus.cmd_k_step = $urandom; bus.cmd_valid = 1;
    while (n_acc - a0 < 2 && t < 300) begin @(posedge CLK); t++; end
    #1 bus.cmd_valid = 0;
    chk(n_acc - a0 == 2, "t7_two_accepts", n_acc - a0, 2);
    chk(last_acc_cyc == last_done_cyc + 1, "t7_accept_after_done", last_acc_cyc, last_done_cyc + 1);
    wait_done(n_done);

    // Randomized commands and ready patterns
    for (int i = 0; i < 10; i++) begin
      rs_mode = $urandom_range(1, 2);
      rn_mode = $urandom_range(1, 2);
      rr_mode = $urandom_range(1, 2);
      d0 = n_done;
      run_cmd($urandom_range(0, 7), $urandom, $urandom);
      wait_done(d0);
    end
    rs_mode = 1; rn_mode = 1; rr_mode = 1;
    repeat (3) @(posedge CLK);
    chk(exp_k.size() == 0, "end_calls_left", exp_k.size(), 0);
    chk(exp_res.size() == 0, "end_results_left", exp_res.size(), 0);
    chk(n_done + n_abort == n_acc, "end_done_per_cmd", n_done + n_abort, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_initiator.md
NEXT_INITIATOR -- requirements
Module: next_initiator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of next_k and next.
REQ-002 SHALL have parameter CNT_W, default 8, width of the request count.
REQ-003 SHALL have parameter RES_DEPTH, default 2, result buffer depth; fixed at 2 in this revision.
REQ-004 SHALL have port CLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1: host command handshake.
REQ-007 SHALL have ports cmd_count in CNT_W, cmd_k_base in DATA_W, cmd_k_step in DATA_W: number of next calls, first k, k increment.
REQ-008 SHALL have ports EN_start out 1, RDY_start in 1: start method enable and ready toward the responder.
REQ-009 SHALL have ports EN_next out 1, RDY_next in 1, next_k out DATA_W, next in DATA_W: next method toward the responder.
REQ-010 SHALL have ports res_valid out 1, res_ready in 1, res_data out DATA_W, res_last out 1: result stream.
REQ-011 SHALL have ports busy out 1 and done out 1 (one-cycle pulse).

Function
REQ-012 SHALL implement FSM states IDLE, START, ISSUE, DRAIN.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready, latching count, base and step, then moving to START.
REQ-014 SHALL drive EN_start=RDY_start in START only; it leaves START the cycle after EN_start&&RDY_start, going to ISSUE, or to DRAIN when count==0.
REQ-015 SHALL drive EN_next=1 in ISSUE only when RDY_next=1, remaining>0 and the result buffer is not full; EN_next is never high while RDY_next=0.
REQ-016 SHALL present next_k=base+i*step mod 2^DATA_W for call i (0-based); it uses a running adder with no multiplier, and wrap-around is silent.
REQ-017 SHALL capture next into the result buffer in the same cycle as EN_next&&RDY_next (zero-latency return), tagging res_last=1 on call count-1.
REQ-018 SHALL go to DRAIN after the final call is issued; it stays in DRAIN until the buffer is empty, then returns to IDLE.
REQ-019 SHALL pulse done for exactly one cycle on the DRAIN->IDLE transition, including for count==0.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 SHALL operate the result buffer as a 2-entry FIFO with first-word fall-through; res_valid=!empty and res_data/res_last come from the head.
REQ-022 SHALL pop on res_valid&&res_ready; push and pop in the same cycle are both honoured and occupancy is unchanged; push is impossible when full per REQ-015.
REQ-023 SHALL sustain one next call per cycle when res_ready is held high.
REQ-024 SHALL ignore cmd_valid while busy; commands are neither queued nor dropped silently, because cmd_ready=0.

Reset
REQ-025 SHALL, while RST=1, force state=IDLE, FIFO empty, and the following outputs to 0: EN_start, EN_next, res_valid, res_last, done, busy, next_k, res_data; cmd_ready is 1 on the first cycle after RST falls.
REQ-026 SHALL abort an operation in progress when RST is asserted mid-operation, discarding buffered results, with no EN_* asserted in the reset cycle.

Structure
REQ-027 SHALL take the FSM state enum, DATA_W/CNT_W defaults and the result entry type {last,data} from shared package next_if_pkg.
REQ-028 SHALL instantiate one sub-module, next_res_fifo (2-entry FWFT FIFO, push/pop/full/empty), with the same CLK/RST.

Verification
REQ-029 SHALL cover basic sequencing: responder next=k+1, always ready; cmd count=3, base=10, step=5, res_ready=1 -> EN_start once, then next_k 10,15,20 on consecutive cycles; results 11,16,21 with last on 21; done one cycle after the drain completes.
REQ-030 SHALL cover backpressure: count=4, res_ready=0 -> exactly 2 EN_next then stall with FIFO full; releasing res_ready delivers 4 results in order with no loss or duplication.
REQ-031 SHALL cover responder not ready: RDY_start low for 5 cycles, then RDY_next toggling -> EN_* never high while RDY_* low; results still in order.
REQ-032 SHALL cover the count==0 and wrap boundaries: count=0 -> one EN_start, no EN_next, no res_valid, done pulse; count=2, base=0xFFFFFFFF, step=1 -> next_k 0xFFFFFFFF then 0x00000000.
REQ-033 SHALL cover reset mid-operation: RST asserted 1 cycle after the second EN_next of a count=5 command -> all outputs per REQ-025, FIFO empty; a new command afterwards runs cleanly.
REQ-034 SHALL cover command during busy: cmd_valid held high throughout a count=3 operation -> second command accepted only in the first IDLE cycle after done.
